dmem_arbiter: RTL and testbench

Arbitrates the single data-memory port between the pipeline core (stage-2 load/store) and a second requester, the network interface (NIC). The core has default priority. A starvation counter guarantees the NIC a slot after a bounded wait. The block also routes the one-cycle-latency read data back to whichever requester issued the read. It sits between the pipeline's dmem outputs and the physical data memory, and drives a stall back to the pipeline when the core loses arbitration.

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_return_router.sv | 42 ++++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter and its read-return router.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_WIDTH = 32;
    localparam int DMEM_DATA_WIDTH = 64;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_NIC  = 1'b1
    } owner_e;

    typedef enum logic {
        PRIO_CORE = 1'b0,
        PRIO_NIC  = 1'b1
    } prio_state_e;

endpackage

// File: rtl/dmem_return_router.sv
// Tracks the single outstanding read and steers the one-cycle-latency read data to its issuer.
module dmem_return_router
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_issue_i,
    input  owner_e                rd_owner_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    output logic                  core_rvalid_o,
    output logic [DATA_WIDTH-1:0] nic_rdata_o,
    output logic                  nic_rvalid_o
);

    logic   rd_pending_q, rd_pending_d;
    owner_e rd_owner_q,   rd_owner_d;

    always_comb begin
        rd_pending_d = rd_issue_i;
        rd_owner_d   = rd_issue_i ? rd_owner_i : rd_owner_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWN_CORE;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // The non-owner sees zero so neither side can latch stale data.
    assign core_rvalid_o = rd_pending_q && (rd_owner_q == OWN_CORE);
    assign nic_rvalid_o  = rd_pending_q && (rd_owner_q == OWN_NIC);
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    assign nic_rdata_o   = nic_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the data-memory port with a starvation escape for the NIC.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_stall,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rvalid,
    input  logic                  nic_req,
    input  logic                  nic_we,
    input  logic [ADDR_WIDTH-1:0] nic_addr,
    input  logic [DATA_WIDTH-1:0] nic_wdata,
    output logic                  nic_gnt,
    output logic [DATA_WIDTH-1:0] nic_rdata,
    output logic                  nic_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    prio_state_e      state_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_inc;
    logic             core_win, nic_win;

    always_comb begin
        core_win = 1'b0;
        nic_win  = 1'b0;
        if (!rst) begin
            if (state_q == PRIO_NIC && nic_req) nic_win = 1'b1;
            else if (core_req)                  core_win = 1'b1;
            else if (nic_req)                   nic_win = 1'b1;
        end
    end

    always_comb begin
        mem_en    = core_win | nic_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_win) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (nic_win) begin
            mem_we    = nic_we;
            mem_addr  = nic_addr;
            mem_wdata = nic_wdata;
        end
    end

    assign nic_gnt    = nic_win;
    assign core_stall = core_req & ~core_win & ~rst;

    assign starve_inc = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PRIO_CORE;
            starve_cnt_q <= '0;
        end else begin
            case (state_q)
                PRIO_CORE: begin
                    if (nic_req && !nic_win) begin
                        starve_cnt_q <= starve_inc;
                        if (starve_inc == LIMIT) state_q <= PRIO_NIC;
                    end else begin
                        starve_cnt_q <= '0;
                    end
                end
                PRIO_NIC: begin
                    // A NIC grant or a withdrawn request both end the forced-priority slot.
                    if (nic_win || !nic_req) begin
                        state_q      <= PRIO_CORE;
                        starve_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q      <= PRIO_CORE;
                    starve_cnt_q <= '0;
                end
            endcase
        end
    end

    dmem_return_router #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ret (
        .clk          (clk),
        .rst          (rst),
        .rd_issue_i   (mem_en & ~mem_we),
        .rd_owner_i   (nic_win ? OWN_NIC : OWN_CORE),
        .mem_rdata_i  (mem_rdata),
        .core_rdata_o (core_rdata),
        .core_rvalid_o(core_rvalid),
        .nic_rdata_o  (nic_rdata),
        .nic_rvalid_o (nic_rvalid)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector-table bench for dmem_arbiter with a scoreboard for read returns.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req = 0, core_we = 0, nic_req = 0, nic_we = 0;
    logic [AW-1:0] core_addr = '0, nic_addr = '0;
    logic [DW-1:0] core_wdata = '0, nic_wdata = '0;
    logic          core_stall, core_rvalid, nic_gnt, nic_rvalid;
    logic [DW-1:0] core_rdata, nic_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .nic_req(nic_req), .nic_we(nic_we), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
        .nic_gnt(nic_gnt), .nic_rdata(nic_rdata), .nic_rvalid(nic_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // Memory model: read data appears one cycle after the address is presented.
    always @(posedge clk) mem_rdata <= memf(mem_addr);

    typedef struct {
        logic          rst;
        logic          creq, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          nreq, nwe;
        logic [AW-1:0] naddr;
        logic [DW-1:0] nwd;
        logic [1:0]    win;   // 0 none, 1 core, 2 nic
    } vec_t;

    typedef struct {
        logic          cv, nv;
        logic [DW-1:0] d;
    } ret_t;

    vec_t vecs[$];
    ret_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic r, input logic cq, input logic cw, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input logic nq, input logic nw,
                                input logic [AW-1:0] na, input logic [DW-1:0] nd, input logic [1:0] w);
        vec_t v;
        v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.nreq = nq; v.nwe = nw; v.naddr = na; v.nwd = nd; v.win = w;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        ret_t          e, n;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        rst = v.rst;
        core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwd;
        nic_req = v.nreq;  nic_we = v.nwe;  nic_addr = v.naddr;  nic_wdata = v.nwd;
        #1;
        ew = 1'b0; ea = '0; ed = '0;
        if (v.win == 2'd1) begin ew = v.cwe; ea = v.caddr; ed = v.cwd; end
        if (v.win == 2'd2) begin ew = v.nwe; ea = v.naddr; ed = v.nwd; end
        chk("mem_en",     idx, DW'(mem_en),     DW'(v.win != 2'd0));
        chk("mem_we",     idx, DW'(mem_we),     DW'(ew));
        chk("mem_addr",   idx, DW'(mem_addr),   DW'(ea));
        chk("mem_wdata",  idx, mem_wdata,       ed);
        chk("nic_gnt",    idx, DW'(nic_gnt),    DW'(v.win == 2'd2));
        chk("core_stall", idx, DW'(core_stall), DW'(v.creq && !v.rst && v.win != 2'd1));
        e = sb.pop_front();
        if (v.rst) begin e.cv = 1'b0; e.nv = 1'b0; e.d = '0; end
        chk("core_rvalid", idx, DW'(core_rvalid), DW'(e.cv));
        chk("nic_rvalid",  idx, DW'(nic_rvalid),  DW'(e.nv));
        chk("core_rdata",  idx, core_rdata, e.cv ? e.d : '0);
        chk("nic_rdata",   idx, nic_rdata,  e.nv ? e.d : '0);
        n.cv = (v.win == 2'd1) && !v.cwe;
        n.nv = (v.win == 2'd2) && !v.nwe;
        n.d  = memf(ea);
        sb.push_back(n);
    endtask

    initial begin
        ret_t z;
        z.cv = 1'b0; z.nv = 1'b0; z.d = '0;
        sb.push_back(z);
        // reset with both requesting, then core read 0x10
        vecs.push_back(mk(1, 1, 0, 32'h10, 64'h0, 1, 0, 32'h20, 64'h0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h10, 64'h1, 1, 1, 32'h20, 64'h2, 0));
        vecs.push_back(mk(0, 1, 0, 32'h10, 64'h0, 0, 0, 32'h0,  64'h0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,  64'h0, 0, 0, 32'h0,  64'h0, 0));
        // NIC write alone
        vecs.push_back(mk(0, 0, 0, 32'h0,  64'h0, 1, 1, 32'h20, 64'hDEAD, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,  64'h0, 0, 0, 32'h0,  64'h0, 0));
        // continuous contention: C,C,C,C,N twice
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 1, 0, 32'h30 + i, 64'h0, 1, 0, 32'h40 + i, 64'h0, (i % 5 == 4) ? 2'd2 : 2'd1));
        vecs.push_back(mk(0, 0, 0, 32'h0,  64'h0, 0, 0, 32'h0,  64'h0, 0));
        // alternating owners back to back
        vecs.push_back(mk(0, 1, 0, 32'h100, 64'h0, 0, 0, 32'h0,   64'h0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   64'h0, 1, 0, 32'h200, 64'h0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,   64'h0, 0, 0, 32'h0,   64'h0, 0));
        // build partial starvation, core read in flight, then reset
        vecs.push_back(mk(0, 1, 0, 32'h2F0, 64'h0, 1, 0, 32'h600, 64'h0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h300, 64'h0, 1, 0, 32'h600, 64'h0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h300, 64'h0, 1, 0, 32'h600, 64'h0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   64'h0, 0, 0, 32'h0,   64'h0, 0));
        // counter restarted from zero: four core wins before the NIC
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 1, 32'h400 + i, 64'h11 + i, 1, 1, 32'h700, 64'h77, (i == 4) ? 2'd2 : 2'd1));
        // reach the limit, then NIC withdraws: core granted without stall
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 0, 32'h440 + i, 64'h0, 1, 0, 32'h740, 64'h0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h500, 64'h55, 0, 0, 32'h0, 64'h0, 1));
        // back in core priority with a cleared counter
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 0, 32'h800 + i, 64'h0, 1, 0, 32'h900 + i, 64'h0, (i == 4) ? 2'd2 : 2'd1));
        vecs.push_back(mk(0, 0, 0, 32'h0,  64'h0, 0, 0, 32'h0,  64'h0, 0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
